mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- STARVE_LIMIT, 4, consecutive denied fetch cycles before fetch is forced to win.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request; held until granted.
- if_addr  in  ADDR_W  fetch address (pc).
- if_gnt  out  1  fetch request accepted this cycle.
- if_stall  out  1  if_req && !if_gnt.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch instruction word.
- dm_req  in  1  data-stage request; held until granted.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_gnt  out  1  data request accepted this cycle.
- dm_rvalid  out  1  data read data valid.
- dm_rdata  out  DATA_W  data read word.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid one cycle after read strobe.

Function
REQ-003 Arbiter SHALL grant at most one request per cycle; grant SHALL be combinational in the request cycle.
REQ-004 Default priority SHALL be data over fetch.
REQ-005 On grant, mem_en=1, mem_we=dm_we&&dm_gnt, mem_addr/mem_wdata SHALL come from the winner in the same cycle; with no grant, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-006 A read-owner FSM SHALL have states IDLE, RD_FETCH, RD_DATA. Next state: RD_FETCH if fetch granted; RD_DATA if data read granted; IDLE otherwise, including data writes. Transitions apply from any state.
REQ-007 In RD_FETCH: if_rvalid=1 and if_rdata=mem_rdata. In RD_DATA: dm_rvalid=1 and dm_rdata=mem_rdata. Otherwise rvalid=0 and rdata=0. Read latency SHALL be exactly 1 cycle after grant.
REQ-008 Back-to-back grants SHALL be allowed: a new grant in the same cycle as an rvalid SHALL be accepted with no bubble.
REQ-009 Writes SHALL complete in the grant cycle and SHALL never produce rvalid.
REQ-010 Requests without a grant SHALL have no side effects. A requester dropping req before grant SHALL be legal.

Reset
REQ-011 Asserting reset (low) SHALL asynchronously force state=IDLE and starvation counter=0. While reset is low, gnt, rvalid, mem_en and mem_we SHALL be 0.
REQ-012 A read outstanding at reset SHALL be discarded: no rvalid in the first cycle after release.

Configuration
REQ-013 With MEM_ARB_STARVE_GUARD_EN defined, a counter SHALL increment each cycle that if_req && !if_gnt, saturating at STARVE_LIMIT. When it reaches STARVE_LIMIT, fetch SHALL win the next arbitration even if dm_req=1. The counter SHALL clear on fetch grant or when if_req=0.
REQ-014 Without MEM_ARB_STARVE_GUARD_EN, priority SHALL be strictly fixed data-over-fetch, and no counter logic SHALL exist.

Structure
REQ-015 Package mem_arb_pkg SHALL hold the owner-state enum (IDLE, RD_FETCH, RD_DATA) and default width constants ADDR_W/DATA_W.
REQ-016 Starvation logic SHALL be a sub-module mem_arb_starve_ctr, instantiated only under MEM_ARBITER's macro; everything else SHALL be flat.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- if_req=1, if_addr=0x0010, dm_req=0 -> if_gnt=1, mem_addr=0x0010 the same cycle; next cycle if_rvalid=1, if_rdata=mem_rdata.
- if_req=1 and dm_req=1, dm_we=0, dm_addr=0x0200 together -> dm_gnt=1, if_gnt=0, if_stall=1; next cycle dm_rvalid=1, and fetch granted if dm_req=0.
- dm_req=1, dm_we=1, dm_addr=0x0300, dm_wdata=0xBEEF -> mem_we=1, mem_wdata=0xBEEF; next cycle dm_rvalid=0.
- With MEM_ARB_STARVE_GUARD_EN and STARVE_LIMIT=4: dm_req held high 6 cycles, if_req high throughout -> if_gnt=1 in the 5th cycle, dm_gnt=1 in the others.
- Fetch granted, reset pulled low the next cycle before the edge -> if_rvalid=0 immediately; after release, no rvalid until a new grant.
- Alternating fetch/data reads every cycle for 8 cycles -> 8 grants, each rvalid routed to the correct requester exactly 1 cycle later.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and default widths for the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_FETCH = 2'd1,
        RD_DATA  = 2'd2
    } owner_e;

endpackage
`default_nettype wire

// File: rtl/mem_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_starve_ctr
// Description : Counts consecutive denied fetch cycles and flags when fetch
//               must be forced to win the next arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req,
    input  logic if_gnt,
    output logic starve
);

    localparam int                 c_cnt_w = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(STARVE_LIMIT);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    // Saturates at the limit; any fetch grant or dropped request restarts it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            r_cnt <= '0;
        end else if (r_cnt != c_limit) begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign starve = (r_cnt == c_limit);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Single-port memory arbiter, data over fetch, 1-cycle reads.
//               Define MEM_ARB_STARVE_GUARD_EN to add fetch starvation guard.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W       = mem_arb_pkg::ADDR_W,
    parameter int DATA_W       = mem_arb_pkg::DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_stall,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    import mem_arb_pkg::*;

    logic   w_force_fetch;
    owner_e r_state;
    owner_e w_state_nxt;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic w_starve;

    mem_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk    (clk),
        .reset  (reset),
        .if_req (if_req),
        .if_gnt (if_gnt),
        .starve (w_starve)
    );

    assign w_force_fetch = w_starve;
`else
    logic w_unused_limit;

    assign w_unused_limit = ^STARVE_LIMIT;
    assign w_force_fetch  = 1'b0;
`endif

    // Grants are gated by reset so nothing reaches memory while held in reset.
    assign dm_gnt   = reset && dm_req && !(w_force_fetch && if_req);
    assign if_gnt   = reset && if_req && !dm_gnt;
    assign if_stall = if_req && !if_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = if_addr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The owner state remembers who issued last cycle's read; writes leave it idle.
    always_comb begin
        w_state_nxt = IDLE;
        if_rvalid   = 1'b0;
        if_rdata    = '0;
        dm_rvalid   = 1'b0;
        dm_rdata    = '0;

        if (if_gnt) begin
            w_state_nxt = RD_FETCH;
        end else if (dm_gnt && !dm_we) begin
            w_state_nxt = RD_DATA;
        end

        case (r_state)
            RD_FETCH: begin
                if_rvalid = 1'b1;
                if_rdata  = mem_rdata;
            end
            RD_DATA: begin
                dm_rvalid = 1'b1;
                dm_rdata  = mem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
